z80_int_ctl: RTL and testbench
==============================

// Module: z80_int_ctl
// PURPOSE
//  Vectored IM2 interrupt controller feeding the z80_top interrupt pins. Latches rising edges
//  on up to NUM_SRC peripheral request lines, prioritises them (index 0 highest), drives nINT,
//  supplies the vector byte during the CPU interrupt-acknowledge cycle, and tracks nested
//  in-service levels until end-of-interrupt.
// PARAMETERS
//  NUM_SRC   8      number of request sources (1..8)
//  VEC_BASE  8'hE0  vector base; vector = VEC_BASE | (idx << 1), bit0 always 0
// PORTS
//  CLK        in   1        system clock, all logic on rising edge
//  RESET      in   1        asynchronous, active-high reset
//  irq_req    in   NUM_SRC  request lines, synchronous to CLK; rising edge = request
//  irq_mask   in   NUM_SRC  1 = source masked (still latched, never presented)
//  nM1        in   1        CPU M1, active low
//  nIORQ      in   1        CPU IORQ, active low
//  nMREQ      in   1        CPU MREQ, active low (used only with RETI snoop)
//  D_in       in   8        CPU data bus input (used only with RETI snoop)
//  eoi        in   1        1-cycle end-of-interrupt strobe
//  nINT       out  1        interrupt request to CPU, active low
//  D_out      out  8        vector byte
//  D_oe       out  1        1 = controller drives D_out onto data bus
//  in_service out  NUM_SRC  in-service bit per source
// BEHAVIOUR
//  Reset: pending=0, in_service=0, edge regs=0, state=IDLE, nINT=1, D_oe=0, D_out=8'h00.
//  - Edge detect: pending[i] set on cycle where irq_req[i]=1 and previous sample=0. Set wins
//    over any clear of the same bit in the same cycle.
//  - Candidate = lowest index i with pending[i] & ~irq_mask[i]; eligible only if i is strictly
//    lower than the lowest set in_service index (or in_service==0). Ties impossible.
//  - FSM states IDLE, REQ, ACK:
//    IDLE: eligible candidate exists -> REQ next cycle (nINT low 1 cycle after the edge is latched).
//    REQ: nINT=0. Candidate recomputed every cycle (higher-priority arrival replaces it). If
//      candidate disappears (masked) before ack -> IDLE, nINT=1. On a cycle sampling nM1=0 and
//      nIORQ=0 -> ACK; captured idx registered; pending[idx] cleared; in_service[idx] set.
//    ACK: nINT=1, D_oe=1, D_out=VEC_BASE|(idx<<1), stable entire state. Leave to IDLE on first
//      cycle sampling nIORQ=1; D_oe=0 that same edge. Latency ack-sample -> D_oe = 1 cycle.
//  - nM1&nIORQ low while IDLE: ignored, D_oe stays 0.
//  - eoi: clears the lowest-index set in_service bit; eoi with in_service==0 is a no-op.
//    eoi in same cycle as ack: ack set applied, then eoi clears lowest set bit (may be the new one).
//  - in_service nesting: a new candidate preempts only a lower-priority in-service level.
//  - RESET asserted mid-ACK: D_oe drops to 0 asynchronously, all state cleared.
//  - NUM_SRC<8: unused vector index bits zero; no wrap in vector arithmetic (idx<=7).
// CONFIGURATION
//  Z80_INT_RETI_SNOOP_EN defined: opcode bytes captured from D_in when nM1=0, nMREQ=0;
//    sequence ED then 4D on two consecutive M1 fetches acts exactly as one eoi strobe
//    (OR-ed with eoi; both in same cycle = single clear). Any other byte after ED resets match.
//  Not defined: nMREQ and D_in ignored; only eoi clears in_service.
// TESTING
//  1 Reset: RESET=1 with irq_req toggling -> nINT=1, D_oe=0, in_service=0, pending stays 0.
//  2 Single: pulse irq_req[3] -> nINT=0 next cycle; nM1=nIORQ=0 -> D_oe=1, D_out=8'hE6,
//    in_service=8'h08; nIORQ=1 -> D_oe=0; eoi -> in_service=0.
//  3 Priority: edges on [5] and [2] same cycle -> vector 8'hE4 first; after eoi, 8'hEA.
//  4 Nesting: in_service[4] set, edge [6] -> nINT stays 1; edge [1] -> nINT=0, ack vector 8'hE2,
//    in_service=8'h12; eoi -> 8'h10.
//  5 Mask/abort: edge [0] with mask[0]=1 -> nINT=1; unmask -> nINT=0; remask in REQ -> nINT=1.
//  6 RETI (macro on): fetch ED,4D on M1 with in_service=8'h04 -> in_service=0; ED,00 -> no change.

Source files
------------

// File: rtl/z80_int_ctl_if.sv
// z80_int_ctl_if: request, CPU bus and vector signals between the IM2 interrupt controller and its environment
interface z80_int_ctl_if #(parameter int NUM_SRC = 8);
  logic [NUM_SRC-1:0] irq_req, irq_mask, in_service;
  logic nM1, nIORQ, nMREQ, eoi, nINT, D_oe;
  logic [7:0] D_in, D_out;
  modport master(output irq_req, irq_mask, nM1, nIORQ, nMREQ, D_in, eoi, input nINT, D_out, D_oe, in_service);
  modport slave(input irq_req, irq_mask, nM1, nIORQ, nMREQ, D_in, eoi, output nINT, D_out, D_oe, in_service);
endinterface

// File: rtl/z80_int_ctl.sv
// z80_int_ctl: vectored IM2 interrupt controller with edge latching, priority, nesting and EOI.
// Define Z80_INT_RETI_SNOOP_EN to also treat an ED,4D opcode fetch pair as an end-of-interrupt.
module z80_int_ctl #(
  parameter int NUM_SRC = 8,
  parameter logic [7:0] VEC_BASE = 8'hE0
) (
  input logic clk,
  input logic rst,
  z80_int_ctl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2;
  logic [1:0] state, state_nx;
  logic [NUM_SRC-1:0] req_q, pending, in_srv, avail, set_bit, srv_tmp, srv_nx;
  logic [3:0] cand, srv_lo;
  logic [7:0] d_out, vec;
  logic elig, ack, eoi_any;
  assign avail = pending & ~bus.irq_mask;
  always_comb begin
    cand = 4'(NUM_SRC);
    srv_lo = 4'(NUM_SRC);
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (avail[i]) cand = 4'(i);
      if (in_srv[i]) srv_lo = 4'(i);
    end
  end
  // only a source strictly above every active in-service level may interrupt
  assign elig = cand < srv_lo;
  assign ack = state == REQ && elig && !bus.nM1 && !bus.nIORQ;
  assign set_bit = ack ? NUM_SRC'(1) << cand : '0;
  assign srv_tmp = in_srv | set_bit;
  assign srv_nx = eoi_any ? srv_tmp & ~(srv_tmp & (~srv_tmp + NUM_SRC'(1))) : srv_tmp;
  assign vec = VEC_BASE | {4'b0, cand[2:0], 1'b0};
  always_comb
    state_nx = state == IDLE ? (elig ? REQ : IDLE) :
               state == REQ  ? (ack ? ACK : elig ? REQ : IDLE) :
               (bus.nIORQ ? IDLE : ACK);
`ifdef Z80_INT_RETI_SNOOP_EN
  logic fetch, fetch_q, ed_seen, reti;
  assign fetch = !bus.nM1 && !bus.nMREQ;
  assign reti = fetch && !fetch_q && ed_seen && bus.D_in == 8'h4D;
  assign eoi_any = bus.eoi | reti;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fetch_q <= 1'b0;
      ed_seen <= 1'b0;
    end else begin
      fetch_q <= fetch;
      if (fetch && !fetch_q) ed_seen <= bus.D_in == 8'hED;
    end
`else
  logic unused_snoop;
  assign unused_snoop = &{1'b0, bus.nMREQ, bus.D_in};
  assign eoi_any = bus.eoi;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      req_q <= '0;
      pending <= '0;
      in_srv <= '0;
      d_out <= 8'h00;
    end else begin
      state <= state_nx;
      req_q <= bus.irq_req;
      pending <= (pending & ~set_bit) | (bus.irq_req & ~req_q);
      in_srv <= srv_nx;
      if (ack) d_out <= vec;
    end
  assign bus.nINT = state != REQ;
  assign bus.D_oe = state == ACK;
  assign bus.D_out = d_out;
  assign bus.in_service = in_srv;
endmodule

// File: tb/tb_z80_int_ctl.sv
// tb_z80_int_ctl: scenario tasks plus randomized traffic against a set-based priority/nesting model
module tb_z80_int_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  z80_int_ctl_if #(.NUM_SRC(8)) bus();
  z80_int_ctl #(.NUM_SRC(8), .VEC_BASE(8'hE0)) dut(.clk(clk), .rst(rst), .bus(bus));
  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction
  task tick;
    @(posedge clk);
    #1;
  endtask
  task do_reset;
    rst = 1'b1;
    bus.irq_req = '0; bus.irq_mask = '0; bus.nM1 = 1'b1; bus.nIORQ = 1'b1;
    bus.nMREQ = 1'b1; bus.D_in = 8'h00; bus.eoi = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask
  task pulse(input int i);
    bus.irq_req[i] = 1'b1;
    tick;
    bus.irq_req[i] = 1'b0;
  endtask
  task ack_on;
    bus.nM1 = 1'b0; bus.nIORQ = 1'b0;
    tick;
  endtask
  task ack_off;
    bus.nM1 = 1'b1; bus.nIORQ = 1'b1;
    tick;
  endtask
  task do_eoi;
    bus.eoi = 1'b1;
    tick;
    bus.eoi = 1'b0;
  endtask
  task fetch(input logic [7:0] op);
    bus.nM1 = 1'b0; bus.nMREQ = 1'b0; bus.D_in = op;
    tick;
    bus.nM1 = 1'b1; bus.nMREQ = 1'b1;
    tick;
  endtask
  task test_reset;
    rst = 1'b1;
    bus.irq_mask = '0; bus.nM1 = 1'b1; bus.nIORQ = 1'b1; bus.nMREQ = 1'b1;
    bus.D_in = 8'h00; bus.eoi = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.irq_req = 8'($urandom);
      tick;
      checks++;
      if (bus.nINT !== 1'b1 || bus.D_oe !== 1'b0 || bus.in_service !== 8'h00 || bus.D_out !== 8'h00) begin
        failures++;
        $display("FAIL reset_out nINT=%b D_oe=%b isv=%h D_out=%h exp 1 0 00 00", bus.nINT, bus.D_oe, bus.in_service, bus.D_out);
      end
    end
    bus.irq_req = '0;
    tick;
    rst = 1'b0;
    tick; tick; tick;
    checks++;
    if (bus.nINT !== 1'b1) begin failures++; $display("FAIL reset_pending nINT=%b exp 1", bus.nINT); end
  endtask
  task test_single;
    do_reset;
    pulse(3);
    checks++;
    if (bus.nINT !== 1'b1) begin failures++; $display("FAIL single_latch nINT=%b exp 1", bus.nINT); end
    tick;
    checks++;
    if (bus.nINT !== 1'b0) begin failures++; $display("FAIL single_req nINT=%b exp 0", bus.nINT); end
    ack_on;
    checks++;
    if (bus.D_oe !== 1'b1 || bus.D_out !== 8'hE6 || bus.in_service !== 8'h08 || bus.nINT !== 1'b1) begin
      failures++;
      $display("FAIL single_ack D_oe=%b D_out=%h isv=%h nINT=%b exp 1 e6 08 1", bus.D_oe, bus.D_out, bus.in_service, bus.nINT);
    end
    tick;
    checks++;
    if (bus.D_oe !== 1'b1 || bus.D_out !== 8'hE6) begin failures++; $display("FAIL single_hold D_oe=%b D_out=%h exp 1 e6", bus.D_oe, bus.D_out); end
    ack_off;
    checks++;
    if (bus.D_oe !== 1'b0) begin failures++; $display("FAIL single_release D_oe=%b exp 0", bus.D_oe); end
    do_eoi;
    checks++;
    if (bus.in_service !== 8'h00) begin failures++; $display("FAIL single_eoi isv=%h exp 00", bus.in_service); end
    do_eoi;
    checks++;
    if (bus.in_service !== 8'h00 || bus.nINT !== 1'b1) begin failures++; $display("FAIL eoi_noop isv=%h nINT=%b exp 00 1", bus.in_service, bus.nINT); end
  endtask
  task test_priority;
    do_reset;
    bus.irq_req = 8'h24;
    tick;
    bus.irq_req = '0;
    tick;
    ack_on;
    checks++;
    if (bus.D_out !== 8'hE4 || bus.in_service !== 8'h04) begin failures++; $display("FAIL prio_first D_out=%h isv=%h exp e4 04", bus.D_out, bus.in_service); end
    ack_off;
    tick;
    checks++;
    if (bus.nINT !== 1'b1) begin failures++; $display("FAIL prio_blocked nINT=%b exp 1", bus.nINT); end
    do_eoi;
    tick;
    checks++;
    if (bus.nINT !== 1'b0) begin failures++; $display("FAIL prio_second_req nINT=%b exp 0", bus.nINT); end
    ack_on;
    checks++;
    if (bus.D_out !== 8'hEA || bus.in_service !== 8'h20) begin failures++; $display("FAIL prio_second D_out=%h isv=%h exp ea 20", bus.D_out, bus.in_service); end
    ack_off;
  endtask
  task test_nesting;
    do_reset;
    pulse(4);
    tick;
    ack_on;
    ack_off;
    pulse(6);
    tick; tick;
    checks++;
    if (bus.nINT !== 1'b1 || bus.in_service !== 8'h10) begin failures++; $display("FAIL nest_low nINT=%b isv=%h exp 1 10", bus.nINT, bus.in_service); end
    pulse(1);
    tick;
    checks++;
    if (bus.nINT !== 1'b0) begin failures++; $display("FAIL nest_high_req nINT=%b exp 0", bus.nINT); end
    ack_on;
    checks++;
    if (bus.D_out !== 8'hE2 || bus.in_service !== 8'h12) begin failures++; $display("FAIL nest_ack D_out=%h isv=%h exp e2 12", bus.D_out, bus.in_service); end
    ack_off;
    do_eoi;
    checks++;
    if (bus.in_service !== 8'h10) begin failures++; $display("FAIL nest_eoi isv=%h exp 10", bus.in_service); end
  endtask
  task test_mask;
    do_reset;
    bus.irq_mask = 8'h01;
    pulse(0);
    tick; tick;
    checks++;
    if (bus.nINT !== 1'b1) begin failures++; $display("FAIL mask_hold nINT=%b exp 1", bus.nINT); end
    bus.irq_mask = 8'h00;
    tick; tick;
    checks++;
    if (bus.nINT !== 1'b0) begin failures++; $display("FAIL mask_unmask nINT=%b exp 0", bus.nINT); end
    bus.irq_mask = 8'h01;
    tick;
    checks++;
    if (bus.nINT !== 1'b1 || bus.D_oe !== 1'b0) begin failures++; $display("FAIL mask_abort nINT=%b D_oe=%b exp 1 0", bus.nINT, bus.D_oe); end
  endtask
  task test_idle_ack;
    do_reset;
    ack_on;
    tick;
    checks++;
    if (bus.D_oe !== 1'b0 || bus.in_service !== 8'h00) begin failures++; $display("FAIL idle_ack D_oe=%b isv=%h exp 0 00", bus.D_oe, bus.in_service); end
    ack_off;
  endtask
  task test_back_to_back;
    do_reset;
    pulse(4);
    tick;
    ack_on;
    ack_off;
    pulse(2);
    tick;
    bus.nM1 = 1'b0; bus.nIORQ = 1'b0; bus.eoi = 1'b1;
    tick;
    bus.eoi = 1'b0;
    checks++;
    if (bus.D_oe !== 1'b1 || bus.D_out !== 8'hE4 || bus.in_service !== 8'h10) begin
      failures++;
      $display("FAIL ack_eoi D_oe=%b D_out=%h isv=%h exp 1 e4 10", bus.D_oe, bus.D_out, bus.in_service);
    end
    ack_off;
    pulse(7);
    pulse(3);
    tick;
    checks++;
    if (bus.nINT !== 1'b0) begin failures++; $display("FAIL b2b_req nINT=%b exp 0", bus.nINT); end
  endtask
  task test_async_reset;
    do_reset;
    pulse(5);
    tick;
    ack_on;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.D_oe !== 1'b0 || bus.in_service !== 8'h00 || bus.nINT !== 1'b1) begin
      failures++;
      $display("FAIL async_reset D_oe=%b isv=%h nINT=%b exp 0 00 1", bus.D_oe, bus.in_service, bus.nINT);
    end
    ack_off;
  endtask
`ifdef Z80_INT_RETI_SNOOP_EN
  task test_reti;
    do_reset;
    pulse(2);
    tick;
    ack_on;
    ack_off;
    fetch(8'hED);
    fetch(8'h4D);
    checks++;
    if (bus.in_service !== 8'h00) begin failures++; $display("FAIL reti_clear isv=%h exp 00", bus.in_service); end
    pulse(2);
    tick;
    ack_on;
    ack_off;
    fetch(8'hED);
    fetch(8'h00);
    fetch(8'h4D);
    checks++;
    if (bus.in_service !== 8'h04) begin failures++; $display("FAIL reti_nomatch isv=%h exp 04", bus.in_service); end
  endtask
`endif
  task test_random;
    logic [7:0] pend_m, isv_m, m, r;
    int c, s;
    do_reset;
    pend_m = '0;
    isv_m = '0;
    for (int n = 0; n < 60; n++) begin
      m = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h00;
      r = 8'($urandom) & 8'($urandom);
      bus.irq_mask = m;
      bus.irq_req = r;
      tick;
      bus.irq_req = '0;
      pend_m |= r;
      tick; tick;
      c = lowest(pend_m & ~m);
      s = lowest(isv_m);
      checks++;
      if (bus.nINT !== !(c < s)) begin failures++; $display("FAIL rand_nint it=%0d nINT=%b exp %b", n, bus.nINT, !(c < s)); end
      if (c < s) begin
        ack_on;
        isv_m[c] = 1'b1;
        pend_m[c] = 1'b0;
        checks++;
        if (bus.D_out !== 8'(8'hE0 + 2 * c) || bus.in_service !== isv_m || bus.D_oe !== 1'b1) begin
          failures++;
          $display("FAIL rand_ack it=%0d D_out=%h isv=%h exp %h %h", n, bus.D_out, bus.in_service, 8'(8'hE0 + 2 * c), isv_m);
        end
        ack_off;
      end
      if ($urandom_range(0, 1) == 1) begin
        do_eoi;
        s = lowest(isv_m);
        if (s < 8) isv_m[s] = 1'b0;
        checks++;
        if (bus.in_service !== isv_m) begin failures++; $display("FAIL rand_eoi it=%0d isv=%h exp %h", n, bus.in_service, isv_m); end
      end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_priority;
    test_nesting;
    test_mask;
    test_idle_ack;
    test_back_to_back;
    test_async_reset;
`ifdef Z80_INT_RETI_SNOOP_EN
    test_reti;
`endif
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
